periph_bus: RTL and testbench

PERIPH_BUS -- requirements
Module: periph_bus

---
 rtl/periph_bus_pkg.sv | 27 ++
 rtl/periph_bus_if.sv | 33 +++
 rtl/periph_slot_decoder.sv | 26 ++
 rtl/periph_bus.sv | 140 ++++++++++++++
 tb/tb_periph_bus.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus bridge: FSM states, slot
// addressing geometry and the default slot map.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Each slot owns one 32-bit word of byte address space.
    localparam int SLOT_STRIDE = 4;
    localparam int STRIDE_LSB  = $clog2(SLOT_STRIDE);

    // Wait counter width; TIMEOUT must fit in it.
    localparam int WCNT_W = 4;

    // Default slot map.
    localparam int SLOT_DIN    = 0;
    localparam int SLOT_DOUT   = 1;
    localparam int SLOT_TIMER0 = 2;
    localparam int SLOT_TIMER1 = 3;
    localparam int SLOT_PWM0   = 4;
    localparam int SLOT_ADOUT  = 5;
    localparam int SLOT_7SEG   = 6;

endpackage

// File: rtl/periph_bus_if.sv
// Bundle of the CPU-side request/response signals and the slot-side
// select/ack signals. The slave modport is the bridge's view; the master
// modport is the environment (CPU plus peripherals) driving it.
interface periph_bus_if #(
    parameter int N_SLOTS = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6
);
    // CPU side
    logic                        req;
    logic [ADDR_W-1:0]           A;
    logic [DATA_W-1:0]           WD;
    logic                        WE;
    logic                        rdy;
    logic [DATA_W-1:0]           RD;
    logic                        err;
    // Slot side
    logic [N_SLOTS-1:0]          s_sel;
    logic                        s_WE;
    logic [DATA_W-1:0]           s_WD;
    logic [N_SLOTS*DATA_W-1:0]   s_RD;
    logic [N_SLOTS-1:0]          s_ack;

    modport master (
        output req, A, WD, WE, s_RD, s_ack,
        input  rdy, RD, err, s_sel, s_WE, s_WD
    );

    modport slave (
        input  req, A, WD, WE, s_RD, s_ack,
        output rdy, RD, err, s_sel, s_WE, s_WD
    );
endinterface

// File: rtl/periph_slot_decoder.sv
// Combinational address decoder: byte address -> one-hot slot select plus
// a valid flag. Misaligned or out-of-range addresses give valid=0, sel=0.
module periph_slot_decoder
    import periph_bus_pkg::*;
#(
    parameter int N_SLOTS = 8,
    parameter int ADDR_W  = 6
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [N_SLOTS-1:0] sel,
    output logic               valid
);
    logic [ADDR_W-STRIDE_LSB-1:0] slot;
    logic                         aligned;

    // Slot index is the word address; only word-aligned accesses decode.
    always_comb begin
        slot    = addr[ADDR_W-1:STRIDE_LSB];
        aligned = (addr[STRIDE_LSB-1:0] == '0);
        valid   = aligned && (32'(slot) < 32'(N_SLOTS));
        sel     = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            sel[k] = valid && (32'(slot) == 32'(k));
        end
    end
endmodule

// File: rtl/periph_bus.sv
// Single-outstanding CPU-to-peripheral bridge. A request sampled in IDLE is
// decoded to a slot; the slot is held selected until it acks or the wait
// counter times out, then a one-cycle rdy pulse returns RD/err.
module periph_bus
    import periph_bus_pkg::*;
#(
    parameter int N_SLOTS = 8,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    periph_bus_if.slave bus
);
    // Last ACCESS cycle in which an ack is still accepted; without an ack
    // there the counter reaches TIMEOUT and the access fails.
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [N_SLOTS-1:0]  sel_q,   sel_d;
    logic                we_q,    we_d;
    logic [DATA_W-1:0]   wd_q,    wd_d;
    logic [DATA_W-1:0]   rd_q,    rd_d;
    logic                rdy_q,   rdy_d;
    logic                err_q,   err_d;
    logic [WCNT_W-1:0]   wcnt_q,  wcnt_d;

    logic [N_SLOTS-1:0]  dec_sel;
    logic                dec_valid;
    logic                ack_hit;
    logic [DATA_W-1:0]   slot_rd;

    periph_slot_decoder #(
        .N_SLOTS (N_SLOTS),
        .ADDR_W  (ADDR_W)
    ) u_dec (
        .addr  (bus.A),
        .sel   (dec_sel),
        .valid (dec_valid)
    );

    // Ack and read data are qualified by the latched select, so acks from
    // unselected slots never complete an access.
    always_comb begin
        ack_hit = |(bus.s_ack & sel_q);
        slot_rd = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            if (sel_q[k]) begin
                slot_rd = slot_rd | bus.s_RD[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        rdy_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d   = bus.WE;
                    wd_d   = bus.WD;
                    wcnt_d = '0;
                    if (dec_valid) begin
                        sel_d   = dec_sel;
                        state_d = ACCESS;
                    end else begin
                        sel_d   = '0;
                        rd_d    = '0;
                        err_d   = 1'b1;
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                if (ack_hit) begin
                    rd_d    = we_q ? '0 : slot_rd;
                    err_d   = 1'b0;
                    sel_d   = '0;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end else if (wcnt_q == WCNT_LAST) begin
                    wcnt_d  = wcnt_q + 1'b1;
                    rd_d    = '0;
                    err_d   = 1'b1;
                    sel_d   = '0;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rd_q    <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign bus.s_sel = sel_q;
    assign bus.s_WE  = we_q;
    assign bus.s_WD  = wd_q;
    assign bus.rdy   = rdy_q;
    assign bus.RD    = rd_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_periph_bus.sv
// Randomized scoreboard bench for periph_bus with a reference model of the
// access rules and a responder standing in for the peripherals.
module tb_periph_bus;
    localparam int NS  = 8;
    localparam int DW  = 32;
    localparam int AW  = 6;
    localparam int TMO = 15;

    typedef struct {
        logic          err;
        logic [31:0]   rd;
        int            lat;
        int            selc;
        logic [NS-1:0] sel;
        logic          we;
        logic [31:0]   wd;
        int            issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    periph_bus_if #(.N_SLOTS(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

    periph_bus #(.N_SLOTS(NS), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    exp_t        sb[$];
    bit          bypass = 1'b0;
    int          sel_cnt = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;
    int          ack_delay = 0;
    int          sel_age = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: outcome of one access from the address rules alone.
    function automatic exp_t model(input int addr, input bit we, input logic [31:0] wd,
                                   input int delay, input logic [NS*DW-1:0] srd, input int issue);
        exp_t e;
        int   slot;
        slot    = addr / 4;
        e.we    = we;
        e.wd    = wd;
        e.issue = issue;
        if ((addr % 4) != 0 || slot >= NS) begin
            e.err = 1'b1; e.rd = '0; e.lat = 1; e.selc = 0; e.sel = '0;
        end else begin
            e.sel = NS'(1) << slot;
            if (delay < TMO) begin
                e.err  = 1'b0;
                e.rd   = we ? 32'd0 : srd[slot*DW +: DW];
                e.lat  = delay + 2;
                e.selc = delay + 1;
            end else begin
                e.err = 1'b1; e.rd = '0; e.lat = TMO + 1; e.selc = TMO;
            end
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Peripheral responder: selected slot acks after ack_delay wait cycles;
    // random stray acks appear on unselected slots.
    always @(negedge clk) begin
        logic [NS-1:0] stray;
        stray = NS'($urandom) & ~bus.s_sel;
        if (bus.s_sel != '0) begin
            bus.s_ack = (sel_age == ack_delay) ? (bus.s_sel | stray) : stray;
            sel_age++;
        end else begin
            sel_age   = 0;
            bus.s_ack = stray;
        end
    end

    // Monitor: checks select phase against the front expectation and pops
    // it on every rdy pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            sel_cnt = 0;
        end else if (!bypass) begin
            if (bus.s_sel != '0) begin
                sel_cnt++;
                if (sb.size() == 0) begin
                    chk(1'b0, "sel_without_request", 32'(bus.s_sel), 32'd0);
                end else begin
                    chk(bus.s_sel == sb[0].sel, "s_sel", 32'(bus.s_sel), 32'(sb[0].sel));
                    chk(bus.s_WE == sb[0].we, "s_WE", 32'(bus.s_WE), 32'(sb[0].we));
                    chk(bus.s_WD == sb[0].wd, "s_WD", bus.s_WD, sb[0].wd);
                end
            end
            if (bus.rdy) begin
                if (sb.size() == 0) begin
                    chk(1'b0, "spurious_rdy", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk(bus.err == e.err, "err", 32'(bus.err), 32'(e.err));
                    chk(bus.RD == e.rd, "RD", bus.RD, e.rd);
                    chk(cyc - e.issue + 1 == e.lat, "latency", 32'(cyc - e.issue + 1), 32'(e.lat));
                    chk(sel_cnt == e.selc, "sel_cycles", 32'(sel_cnt), 32'(e.selc));
                    last_rd  = e.rd;
                    last_err = e.err;
                end
                sel_cnt = 0;
            end else begin
                chk(bus.RD == last_rd, "RD_hold", bus.RD, last_rd);
                chk(bus.err == last_err, "err_hold", 32'(bus.err), 32'(last_err));
            end
        end
    end

    task automatic load_slots(output logic [NS*DW-1:0] srd);
        for (int k = 0; k < NS; k++) srd[k*DW +: DW] = $urandom;
        bus.s_RD = srd;
    endtask

    task automatic do_access(input int addr, input bit we, input logic [31:0] wd, input int delay);
        logic [NS*DW-1:0] srd;
        int n;
        load_slots(srd);
        ack_delay = delay;
        @(negedge clk);
        bus.req = 1'b1; bus.A = AW'(addr); bus.WD = wd; bus.WE = we;
        sb.push_back(model(addr, we, wd, delay, srd, cyc + 1));
        @(negedge clk);
        // Scramble CPU inputs to prove the bridge uses its latched copies.
        bus.req = 1'b0; bus.A = AW'($urandom); bus.WD = $urandom; bus.WE = 1'($urandom);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge clk); #2; n++;
        end
        if (sb.size() != 0) begin
            chk(1'b0, "completion_budget", 32'(n), 32'd40);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NS*DW-1:0] srd;
        int prev, npulse;
        rst = 1'b1;
        bus.req = 1'b0; bus.A = '0; bus.WD = '0; bus.WE = 1'b0;
        bus.s_RD = '0; bus.s_ack = '0;
        repeat (3) @(posedge clk);
        #1;
        chk(bus.rdy == 1'b0, "reset_rdy", 32'(bus.rdy), 32'd0);
        chk(bus.s_sel == '0, "reset_s_sel", 32'(bus.s_sel), 32'd0);
        chk(bus.RD == '0, "reset_RD", bus.RD, 32'd0);
        chk(bus.err == 1'b0, "reset_err", 32'(bus.err), 32'd0);
        chk(bus.s_WE == 1'b0 && bus.s_WD == '0, "reset_s_WE_WD", bus.s_WD, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        do_access(8, 1'b0, 32'h0, 0);          // zero-wait read of slot 2
        do_access(4, 1'b1, 32'hA5, 3);         // write slot 1, three waits
        do_access(6'h21, 1'b0, 32'h0, 0);      // misaligned
        do_access(6'h20, 1'b1, 32'h77, 0);     // slot 8, out of range
        do_access(12, 1'b0, 32'h0, 99);        // slot 3 never acks
        do_access(12, 1'b0, 32'h0, TMO - 1);   // ack on the last accepted cycle
        do_access(12, 1'b1, 32'h5, TMO);       // ack one cycle too late

        // Randomized accesses
        for (int i = 0; i < 60; i++) begin
            int addr;
            addr = ($urandom_range(0, 3) != 0) ? 4 * $urandom_range(0, 15) : $urandom_range(0, 63);
            do_access(addr, 1'($urandom), $urandom, $urandom_range(0, TMO + 2));
        end

        // Reset in the middle of an access
        bypass = 1'b1;
        load_slots(srd);
        ack_delay = 99;
        @(negedge clk);
        bus.req = 1'b1; bus.A = 6'd12; bus.WE = 1'b1; bus.WD = 32'hDEAD;
        @(negedge clk);
        bus.req = 1'b0;
        repeat (4) @(negedge clk);
        chk(bus.s_sel == 8'h08, "pre_reset_sel", 32'(bus.s_sel), 32'h08);
        #3 rst = 1'b1;
        #1;
        chk(bus.s_sel == '0, "mid_reset_s_sel", 32'(bus.s_sel), 32'd0);
        chk(bus.rdy == 1'b0, "mid_reset_rdy", 32'(bus.rdy), 32'd0);
        chk(bus.RD == '0 && bus.err == 1'b0, "mid_reset_RD_err", bus.RD, 32'd0);
        last_rd = '0; last_err = 1'b0;
        repeat (2) @(negedge clk);
        chk(bus.rdy == 1'b0, "reset_hold_rdy", 32'(bus.rdy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        bypass = 1'b0;
        do_access(0, 1'b0, 32'h0, 1);

        // req held high: zero-wait reads back to back
        bypass = 1'b1;
        load_slots(srd);
        ack_delay = 0;
        @(negedge clk);
        bus.req = 1'b1; bus.A = 6'd0; bus.WE = 1'b0;
        prev = -1; npulse = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.rdy) begin
                npulse++;
                chk(bus.err == 1'b0 && bus.RD == srd[DW-1:0], "b2b_data", bus.RD, srd[DW-1:0]);
                if (prev >= 0) chk(cyc - prev == 3, "b2b_gap", 32'(cyc - prev), 32'd3);
                prev = cyc;
            end
        end
        chk(npulse == 5, "b2b_pulses", 32'(npulse), 32'd5);
        @(negedge clk);
        bus.req = 1'b0;
        repeat (5) @(negedge clk);
        last_rd = srd[DW-1:0]; last_err = 1'b0;
        bypass = 1'b0;
        do_access(6'h3F, 1'b0, 32'h0, 0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
